// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_pkg
// Description : Shared types for the execute stage: machine word and register
//               index types, control/decode words, ALU and branch operation
//               encodings, and the serial-shift FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package execute_stage_pkg;

    typedef logic [31:0] rvga_word;
    typedef logic [4:0]  rvga_reg;

    typedef enum logic [2:0] {
        e_rvga_inst_type_r = 3'd0,
        e_rvga_inst_type_i = 3'd1,
        e_rvga_inst_type_s = 3'd2,
        e_rvga_inst_type_b = 3'd3,
        e_rvga_inst_type_u = 3'd4,
        e_rvga_inst_type_j = 3'd5,
        e_rvga_inst_type_e = 3'd6
    } rvga_inst_type_e;

    // ALU operation selected by funct3
    typedef enum logic [2:0] {
        e_rvga_art_add  = 3'd0,
        e_rvga_art_sll  = 3'd1,
        e_rvga_art_slt  = 3'd2,
        e_rvga_art_sltu = 3'd3,
        e_rvga_art_xor  = 3'd4,
        e_rvga_art_srl  = 3'd5,
        e_rvga_art_or   = 3'd6,
        e_rvga_art_and  = 3'd7
    } rvga_artop_e;

    // Branch comparison selected by funct3 (2 and 3 are unused encodings)
    typedef enum logic [2:0] {
        e_rvga_br_eq  = 3'd0,
        e_rvga_br_ne  = 3'd1,
        e_rvga_br_lt  = 3'd4,
        e_rvga_br_ge  = 3'd5,
        e_rvga_br_ltu = 3'd6,
        e_rvga_br_geu = 3'd7
    } rvga_brop_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rvga_exec_state_e;

    typedef struct packed {
        logic       rd_w_v;
        logic       dcache_w_v;
        logic       dcache_r_v;
        logic [2:0] funct3;
        logic       imm_v;
        logic       rs1_pc_sel;
        logic       imm_passthrough_v;
        logic       alt_art;
    } rvga_cword_s;

    typedef struct packed {
        logic [6:0]      opcode;
        rvga_inst_type_e inst_type;
    } rvga_dword_s;

    localparam logic [6:0] c_OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE = 7'b0100011;

endpackage
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_if
// Description : Decode -> execute handshake bundle.
//               master : decode side (drives instruction, samples ready)
//               slave  : execute side (samples instruction, drives ready)
//               Signals: dec_v_i, exec_ready_o, decode_pc, decode_imm_data,
//                        decode_rd, rs1_data_i, rs2_data_i, cword_i, dword_i
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_stage_if;
    import execute_stage_pkg::*;

    logic        dec_v_i;
    logic        exec_ready_o;
    rvga_word    decode_pc;
    rvga_word    decode_imm_data;
    rvga_reg     decode_rd;
    rvga_word    rs1_data_i;
    rvga_word    rs2_data_i;
    rvga_cword_s cword_i;
    rvga_dword_s dword_i;

    modport master (
        output dec_v_i, decode_pc, decode_imm_data, decode_rd,
               rs1_data_i, rs2_data_i, cword_i, dword_i,
        input  exec_ready_o
    );

    modport slave (
        input  dec_v_i, decode_pc, decode_imm_data, decode_rd,
               rs1_data_i, rs2_data_i, cword_i, dword_i,
        output exec_ready_o
    );

endinterface
`default_nettype wire

// File: rtl/execute_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : rvga_alu
// Description : Combinational 32-bit ALU selected by funct3/alt_art.
//               Config macro RVGA_EXEC_BARREL_SHIFT_EN: when defined, shifts
//               are done here in one step; otherwise shift ops return operand
//               A unchanged and the execute stage shifts serially.
// Ports       : a_i, b_i (operands), funct3_i, alt_art_i -> result_o
// Revision    : 1.0 - initial release
// ============================================================================
module rvga_alu
    import execute_stage_pkg::*;
(
    input  rvga_word   a_i,
    input  rvga_word   b_i,
    input  logic [2:0] funct3_i,
    input  logic       alt_art_i,
    output rvga_word   result_o
);

    always_comb begin
        result_o = '0;
        case (funct3_i)
            e_rvga_art_add:  result_o = alt_art_i ? (a_i - b_i) : (a_i + b_i);
`ifdef RVGA_EXEC_BARREL_SHIFT_EN
            e_rvga_art_sll:  result_o = a_i << b_i[4:0];
            e_rvga_art_srl:  result_o = alt_art_i ? rvga_word'($signed(a_i) >>> b_i[4:0])
                                                  : (a_i >> b_i[4:0]);
`else
            // Serial shifter owns these; A unchanged is also the n = 0 answer
            e_rvga_art_sll:  result_o = a_i;
            e_rvga_art_srl:  result_o = a_i;
`endif
            e_rvga_art_slt:  result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
            e_rvga_art_sltu: result_o = {31'b0, (a_i < b_i)};
            e_rvga_art_xor:  result_o = a_i ^ b_i;
            e_rvga_art_or:   result_o = a_i | b_i;
            e_rvga_art_and:  result_o = a_i & b_i;
            default:         result_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : Execute stage: operand select, ALU, load/store address,
//               branch resolution, and registered results. Shifts by n > 0
//               run serially (1 bit/cycle) unless RVGA_EXEC_BARREL_SHIFT_EN
//               is defined, in which case every op completes in one cycle.
// Ports       : clk_i, rst_i (async, active-high)
//               dec                - execute_stage_if.slave decode bundle
//               exec_v_o           - one-cycle completion pulse
//               exec_pc/result/store_data/rd, cword_o - registered results
//               br_taken_o/br_target_o - branch resolution
//               illegal_o          - illegal instruction pulse
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage
    import execute_stage_pkg::*;
(
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    execute_stage_if.slave     dec,
    output logic               exec_v_o,
    output rvga_word           exec_pc,
    output rvga_word           exec_result,
    output rvga_word           exec_store_data,
    output rvga_reg            exec_rd,
    output rvga_cword_s        cword_o,
    output logic               br_taken_o,
    output rvga_word           br_target_o,
    output logic               illegal_o
);

    rvga_word    w_op_a;
    rvga_word    w_op_b;
    rvga_word    w_alu_result;
    rvga_word    w_result;
    rvga_word    w_br_target;
    rvga_cword_s w_cword;
    logic        w_is_branch;
    logic        w_is_illegal;
    logic        w_is_mem;
    logic        w_br_taken;
    logic        w_accept;
    logic        w_ready;
    logic        w_start_shift;

    assign w_accept     = dec.dec_v_i & w_ready;
    assign dec.exec_ready_o = w_ready;

    assign w_op_a       = dec.cword_i.rs1_pc_sel ? dec.decode_pc : dec.rs1_data_i;
    assign w_op_b       = dec.cword_i.imm_v ? dec.decode_imm_data : dec.rs2_data_i;
    assign w_is_branch  = (dec.dword_i.inst_type == e_rvga_inst_type_b);
    assign w_is_illegal = (dec.dword_i.inst_type == e_rvga_inst_type_e);
    assign w_is_mem     = (dec.dword_i.opcode == c_OPC_LOAD) |
                          (dec.dword_i.opcode == c_OPC_STORE);
    assign w_br_target  = dec.decode_pc + (dec.decode_imm_data << 1);

    rvga_alu u_alu (
        .a_i       (w_op_a),
        .b_i       (w_op_b),
        .funct3_i  (dec.cword_i.funct3),
        .alt_art_i (dec.cword_i.alt_art),
        .result_o  (w_alu_result)
    );

    // Passthrough wins over everything; memory ops always compute rs1 + imm
    // regardless of funct3 (which carries the access size there).
    always_comb begin
        w_result = w_alu_result;
        if (dec.cword_i.imm_passthrough_v) begin
            w_result = dec.decode_imm_data;
        end else if (w_is_mem) begin
            w_result = dec.rs1_data_i + dec.decode_imm_data;
        end
    end

    always_comb begin
        w_br_taken = 1'b0;
        if (w_is_branch) begin
            case (dec.cword_i.funct3)
                e_rvga_br_eq:  w_br_taken = (dec.rs1_data_i == dec.rs2_data_i);
                e_rvga_br_ne:  w_br_taken = (dec.rs1_data_i != dec.rs2_data_i);
                e_rvga_br_lt:  w_br_taken = ($signed(dec.rs1_data_i) <  $signed(dec.rs2_data_i));
                e_rvga_br_ge:  w_br_taken = ($signed(dec.rs1_data_i) >= $signed(dec.rs2_data_i));
                e_rvga_br_ltu: w_br_taken = (dec.rs1_data_i <  dec.rs2_data_i);
                e_rvga_br_geu: w_br_taken = (dec.rs1_data_i >= dec.rs2_data_i);
                default:       w_br_taken = 1'b0;
            endcase
        end
    end

    // Branches never write the register file
    always_comb begin
        w_cword = dec.cword_i;
        if (w_is_branch) begin
            w_cword.rd_w_v = 1'b0;
        end
    end

`ifdef RVGA_EXEC_BARREL_SHIFT_EN
    assign w_ready       = 1'b1;
    assign w_start_shift = 1'b0;
`else
    rvga_exec_state_e r_state;
    rvga_exec_state_e w_state_next;
    logic [4:0]       r_shift_cnt;
    rvga_word         r_shift_val;
    rvga_word         w_shift_next;
    rvga_word         r_pend_pc;
    rvga_word         r_pend_store;
    rvga_reg          r_pend_rd;
    rvga_cword_s      r_pend_cword;
    logic             r_shift_left;
    logic             r_shift_arith;
    logic             w_shift_done;
    logic             w_is_shift;
    logic [4:0]       w_shamt;

    assign w_shamt    = w_op_b[4:0];
    assign w_is_shift = ~w_is_branch & ~w_is_illegal & ~w_is_mem &
                        ~dec.cword_i.imm_passthrough_v &
                        ((dec.cword_i.funct3 == e_rvga_art_sll) |
                         (dec.cword_i.funct3 == e_rvga_art_srl));
    assign w_start_shift = w_accept & w_is_shift & (w_shamt != 5'd0);
    assign w_ready       = (r_state == IDLE);

    assign w_shift_next = r_shift_left ? {r_shift_val[30:0], 1'b0}
                                       : {r_shift_arith & r_shift_val[31], r_shift_val[31:1]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_shift) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                // Last bit is shifted on this edge, result registered with it
                if (r_shift_cnt == 5'd1) begin
                    w_state_next = IDLE;
                    w_shift_done = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Holds the in-flight shift; outputs only see it on completion
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shift_cnt   <= '0;
            r_shift_val   <= '0;
            r_pend_pc     <= '0;
            r_pend_store  <= '0;
            r_pend_rd     <= '0;
            r_pend_cword  <= '0;
            r_shift_left  <= 1'b0;
            r_shift_arith <= 1'b0;
        end else if (w_start_shift) begin
            r_shift_cnt   <= w_shamt;
            r_shift_val   <= w_op_a;
            r_pend_pc     <= dec.decode_pc;
            r_pend_store  <= dec.rs2_data_i;
            r_pend_rd     <= dec.decode_rd;
            r_pend_cword  <= w_cword;
            r_shift_left  <= (dec.cword_i.funct3 == e_rvga_art_sll);
            r_shift_arith <= dec.cword_i.alt_art;
        end else if (r_state == SHIFT) begin
            r_shift_val   <= w_shift_next;
            r_shift_cnt   <= r_shift_cnt - 5'd1;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exec_v_o        <= 1'b0;
            exec_pc         <= '0;
            exec_result     <= '0;
            exec_store_data <= '0;
            exec_rd         <= '0;
            cword_o         <= '0;
            br_taken_o      <= 1'b0;
            br_target_o     <= '0;
            illegal_o       <= 1'b0;
        end else begin
            // Bubble by default: pulses and side-effect bits drop, data holds
            exec_v_o           <= 1'b0;
            br_taken_o         <= 1'b0;
            illegal_o          <= 1'b0;
            cword_o.rd_w_v     <= 1'b0;
            cword_o.dcache_w_v <= 1'b0;
            cword_o.dcache_r_v <= 1'b0;
            if (w_accept && !w_start_shift) begin
                if (w_is_illegal) begin
                    illegal_o <= 1'b1;
                end else begin
                    exec_v_o        <= 1'b1;
                    exec_pc         <= dec.decode_pc;
                    exec_result     <= w_result;
                    exec_store_data <= dec.rs2_data_i;
                    exec_rd         <= dec.decode_rd;
                    cword_o         <= w_cword;
                    br_taken_o      <= w_br_taken;
                    br_target_o     <= w_br_target;
                end
            end
`ifndef RVGA_EXEC_BARREL_SHIFT_EN
            else if (w_shift_done) begin
                exec_v_o        <= 1'b1;
                exec_pc         <= r_pend_pc;
                exec_result     <= w_shift_next;
                exec_store_data <= r_pend_store;
                exec_rd         <= r_pend_rd;
                cword_o         <= r_pend_cword;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  asynchronous, active-high reset.
REQ-003 dec_v_i  input  1  decode outputs below carry a valid instruction this cycle.
REQ-004 exec_ready_o  input-side  output  1  stage accepts an instruction this cycle; combinational, high only in IDLE.
REQ-005 decode_pc, decode_imm_data  input  32 each  rvga_word instruction PC and sign/zero-extended immediate from decode.
REQ-006 decode_rd  input  5  rvga_reg destination index.
REQ-007 rs1_data_i, rs2_data_i  input  32 each  register-file read data for decode_rs1/decode_rs2.
REQ-008 cword_i  input  rvga_cword_s  control word: rd_w_v, dcache_w_v, dcache_r_v, funct3, imm_v, rs1_pc_sel, imm_passthrough_v, alt_art.
REQ-009 dword_i  input  rvga_dword_s  opcode and inst_type.
REQ-010 exec_v_o  output  1  one-cycle pulse per completed instruction.
REQ-011 exec_pc, exec_result, exec_store_data  output  32 each  PC, ALU/address result, rs2_data for stores.
REQ-012 exec_rd  output  5  destination index; cword_o  output  rvga_cword_s  registered copy of cword_i.
REQ-013 br_taken_o  output  1; br_target_o  output  32  branch resolution, valid with exec_v_o.
REQ-014 illegal_o  output  1  pulse when a valid instruction has inst_type e_rvga_inst_type_e.

Function
REQ-015 Accept = dec_v_i & exec_ready_o; inputs are sampled only on accept; the upstream stage holds inputs while exec_ready_o is low.
REQ-016 Operand A = rs1_pc_sel ? decode_pc : rs1_data_i; operand B = imm_v ? decode_imm_data : rs2_data_i.
REQ-017 ALU by funct3: 0 add (sub when alt_art), 1 sll, 2 slt signed, 3 sltu, 4 xor, 5 srl (sra when alt_art), 6 or, 7 and; all 32-bit modulo 2^32.
REQ-018 Shift amount = B[4:0]; amount 0 returns A unchanged.
REQ-019 imm_passthrough_v forces exec_result = decode_imm_data.
REQ-020 Loads and stores: exec_result = rs1_data_i + decode_imm_data (add, ignoring funct3); exec_store_data = rs2_data_i.
REQ-021 Branch (inst_type b): compare rs1_data_i vs rs2_data_i by funct3: 0 eq, 1 ne, 4 lt, 5 ge, 6 ltu, 7 geu; 2/3 never taken; br_target_o = decode_pc + (decode_imm_data << 1); rd_w_v forced 0.
REQ-022 br_taken_o is 0 for every non-branch instruction.
REQ-023 FSM states IDLE, SHIFT; IDLE -> SHIFT on accept of a sll/srl/sra with amount n > 0; SHIFT shifts 1 bit per cycle for n cycles, then returns to IDLE.
REQ-024 Latency: non-shift or n = 0 accepted at cycle t -> exec_v_o at t+1; shift with n > 0 -> exec_v_o at t+n+1; exec_ready_o low for cycles t+1 .. t+n.
REQ-025 Cycle with no accept -> next cycle exec_v_o = 0, cword_o.rd_w_v/dcache_w_v/dcache_r_v = 0, br_taken_o = 0; data outputs hold.
REQ-026 Illegal instruction -> treated as bubble (side-effect bits 0, br_taken_o 0), exec_v_o = 0, illegal_o = 1 for one cycle.

Reset
REQ-027 rst_i asserted -> state IDLE, shift counter 0, all outputs 0 (cword_o fully cleared), exec_ready_o = 1 once rst_i deasserted.
REQ-028 Reset mid-SHIFT discards the in-flight instruction; no exec_v_o is produced for it.

Configuration
REQ-029 Macro RVGA_EXEC_BARREL_SHIFT_EN defined -> single-cycle barrel shifter, SHIFT state absent, exec_ready_o tied 1, all latencies 1.
REQ-030 RVGA_EXEC_BARREL_SHIFT_EN undefined -> serial shifter per REQ-023/024.

Structure
REQ-031 rvga_types gains rvga_exec_state_e {IDLE, SHIFT} and rvga_brop_e (branch funct3 codes); reuses rvga_word, rvga_reg, rvga_cword_s, rvga_dword_s, rvga_artop_e.
REQ-032 One combinational sub-module rvga_alu (operands, funct3, alt_art -> result, excluding serial shift); FSM, counter, and output registers live in execute_stage.

Verification
REQ-033 addi: rs1 = 5, imm = -3, imm_v = 1, funct3 = 0 -> exec_result = 2, exec_v_o at t+1, rd_w_v = 1.
REQ-034 sub (alt_art = 1): 3 - 5 -> 0xFFFFFFFE; sltu 1 vs 0xFFFFFFFF -> 1; slt same operands -> 0.
REQ-035 sra rs1 = 0x80000000, B = 4, serial -> exec_ready_o low 4 cycles, exec_v_o at t+5, result 0xF8000000; with macro -> t+1.
REQ-036 bne pc = 0x100, imm = 0x8, rs1 = 1, rs2 = 2 -> br_taken_o = 1, br_target_o = 0x110; beq on same operands -> br_taken_o = 0.
REQ-037 rst_i asserted during 2nd SHIFT cycle -> outputs 0 immediately, no exec_v_o; next addi completes normally.
REQ-038 Illegal opcode with dec_v_i = 1 -> illegal_o pulse, exec_v_o = 0, dcache_w_v = 0.
